// File: rtl/sha1_round_sequencer.sv
// SHA-1 block sequencer: loads 16 message words, expands the schedule in place,
// steps the four round units through feed/next and accumulates the chaining value.
module sha1_round_sequencer (
  input  logic         clk,
  input  logic         reset,
  input  logic         init,
  input  logic         in_valid,
  input  logic [31:0]  in_data,
  output logic         in_ready,
  output logic [3:0]   feed,
  output logic [3:0]   next,
  output logic [31:0]  w,
  output logic [31:0]  ia,
  output logic [31:0]  ib,
  output logic [31:0]  ic,
  output logic [31:0]  id,
  output logic [31:0]  ie,
  input  logic [159:0] u0_out,
  input  logic [159:0] u1_out,
  input  logic [159:0] u2_out,
  input  logic [159:0] u3_out,
  output logic [31:0]  h0,
  output logic [31:0]  h1,
  output logic [31:0]  h2,
  output logic [31:0]  h3,
  output logic [31:0]  h4,
  output logic         digest_valid,
  output logic         busy
);

  localparam logic [31:0] IV0 = 32'h67452301;
  localparam logic [31:0] IV1 = 32'hefcdab89;
  localparam logic [31:0] IV2 = 32'h98badcfe;
  localparam logic [31:0] IV3 = 32'h10325476;
  localparam logic [31:0] IV4 = 32'hc3d2e1f0;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FEED,
    ROUND,
    DONE
  } state_t;

  state_t      state;
  logic [3:0]  count;
  logic [6:0]  t;
  logic [1:0]  stage;
  logic [4:0]  rnd;
  logic [31:0] sr [16];
  logic [159:0] us_out;
  logic        accept;
  logic        handoff;

  function automatic logic [31:0] rotl1(input logic [31:0] x);
    return {x[30:0], x[31]};
  endfunction

  assign accept  = in_valid && in_ready;
  // The last round of stages 0..2 passes the unit's result to the next unit
  // instead of advancing it; stage 3 advances on t=79 as well.
  assign handoff = (state == ROUND) && (rnd == 5'd19) && (t != 7'd79);

  always_comb begin
    us_out = u0_out;
    unique case (stage)
      2'd0: us_out = u0_out;
      2'd1: us_out = u1_out;
      2'd2: us_out = u2_out;
      2'd3: us_out = u3_out;
      default: us_out = u0_out;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      t     <= '0;
      stage <= '0;
      rnd   <= '0;
      h0    <= IV0;
      h1    <= IV1;
      h2    <= IV2;
      h3    <= IV3;
      h4    <= IV4;
    end else begin
      unique case (state)
        IDLE: begin
          if (init) begin
            h0 <= IV0;
            h1 <= IV1;
            h2 <= IV2;
            h3 <= IV3;
            h4 <= IV4;
          end
          if (in_valid) begin
            count <= 4'd1;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (in_valid) begin
            if (count == 4'd15) begin
              count <= '0;
              state <= FEED;
            end else begin
              count <= count + 4'd1;
            end
          end
        end
        FEED: begin
          t     <= '0;
          stage <= '0;
          rnd   <= '0;
          state <= ROUND;
        end
        ROUND: begin
          if (t == 7'd79) begin
            h0    <= h0 + u3_out[159:128];
            h1    <= h1 + u3_out[127:96];
            h2    <= h2 + u3_out[95:64];
            h3    <= h3 + u3_out[63:32];
            h4    <= h4 + u3_out[31:0];
            t     <= '0;
            stage <= '0;
            rnd   <= '0;
            state <= DONE;
          end else begin
            t <= t + 7'd1;
            if (rnd == 5'd19) begin
              rnd   <= '0;
              stage <= stage + 2'd1;
            end else begin
              rnd <= rnd + 5'd1;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Message schedule: loaded words enter at the top; during rounds the window
  // slides down one word per cycle and the new word W[t+16] enters at the top.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) sr[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < 15; i++) sr[i] <= sr[i+1];
      sr[15] <= in_data;
    end else if (state == ROUND) begin
      for (int i = 0; i < 15; i++) sr[i] <= sr[i+1];
      sr[15] <= rotl1(sr[13] ^ sr[8] ^ sr[2] ^ sr[0]);
    end
  end

  always_comb begin
    in_ready     = (state == IDLE) || (state == LOAD);
    busy         = (state != IDLE);
    digest_valid = (state == DONE);
    feed         = '0;
    next         = '0;
    w            = '0;
    ia           = '0;
    ib           = '0;
    ic           = '0;
    id           = '0;
    ie           = '0;
    unique case (state)
      FEED: begin
        feed = 4'b0001;
        ia   = h0;
        ib   = h1;
        ic   = h2;
        id   = h3;
        ie   = h4;
      end
      ROUND: begin
        w = sr[0];
        if (handoff) begin
          feed[stage + 2'd1] = 1'b1;
          {ia, ib, ic, id, ie} = us_out;
        end else begin
          next[stage] = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sha1_round_sequencer.sv
// Bench for sha1_round_sequencer: four behavioural round units are attached and
// known SHA-1 digests, strobe timing and schedule words are checked.
module tb_sha1_round_sequencer;

  localparam logic [159:0] IV_H  = 160'h67452301efcdab8998badcfe10325476c3d2e1f0;
  localparam logic [159:0] ABC_H = 160'ha9993e364706816aba3e25717850c26c9cd0d89d;
  localparam logic [159:0] EMP_H = 160'hda39a3ee5e6b4b0d3255bfef95601890afd80709;
  localparam logic [159:0] TWO_H = 160'h84983e441c3bd26ebaae4aa1f95129e5e54670f1;

  logic         clk = 1'b0;
  logic         reset, init, in_valid;
  logic [31:0]  in_data;
  logic         in_ready, digest_valid, busy;
  logic [3:0]   feed, next;
  logic [31:0]  w, ia, ib, ic, id, ie, h0, h1, h2, h3, h4;
  logic [159:0] ust [4];
  logic [159:0] uo [4];

  int nvec = 0;
  int nerr = 0;
  logic [31:0] msg [16];
  logic [31:0] wexp [80];

  always #5 clk = ~clk;

  sha1_round_sequencer dut (
    .clk(clk), .reset(reset), .init(init), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .feed(feed), .next(next), .w(w),
    .ia(ia), .ib(ib), .ic(ic), .id(id), .ie(ie),
    .u0_out(uo[0]), .u1_out(uo[1]), .u2_out(uo[2]), .u3_out(uo[3]),
    .h0(h0), .h1(h1), .h2(h2), .h3(h3), .h4(h4),
    .digest_valid(digest_valid), .busy(busy)
  );

  function automatic logic [159:0] sha_round(input int k, input logic [159:0] s,
                                             input logic [31:0] wv);
    logic [31:0] a, b, c, d, e, f, kc, tmp;
    {a, b, c, d, e} = s;
    case (k)
      0: begin f = (b & c) | (~b & d); kc = 32'h5a827999; end
      1: begin f = b ^ c ^ d; kc = 32'h6ed9eba1; end
      2: begin f = (b & c) | (b & d) | (c & d); kc = 32'h8f1bbcdc; end
      default: begin f = b ^ c ^ d; kc = 32'hca62c1d6; end
    endcase
    tmp = {a[26:0], a[31:27]} + f + e + kc + wv;
    return {tmp, a, {b[1:0], b[31:2]}, c, d};
  endfunction

  always_comb begin
    for (int k = 0; k < 4; k++) uo[k] = sha_round(k, ust[k], w);
  end

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (feed[k]) ust[k] <= {ia, ib, ic, id, ie};
      else if (next[k]) ust[k] <= uo[k];
    end
  end

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic set_block(input int kind);
    for (int i = 0; i < 16; i++) msg[i] = 32'h0;
    case (kind)
      0: begin msg[0] = 32'h61626380; msg[15] = 32'h00000018; end
      1: msg[0] = 32'h80000000;
      2: begin
        msg[0]  = 32'h61626364; msg[1]  = 32'h62636465; msg[2]  = 32'h63646566;
        msg[3]  = 32'h64656667; msg[4]  = 32'h65666768; msg[5]  = 32'h66676869;
        msg[6]  = 32'h6768696a; msg[7]  = 32'h68696a6b; msg[8]  = 32'h696a6b6c;
        msg[9]  = 32'h6a6b6c6d; msg[10] = 32'h6b6c6d6e; msg[11] = 32'h6c6d6e6f;
        msg[12] = 32'h6d6e6f70; msg[13] = 32'h6e6f7071; msg[14] = 32'h80000000;
      end
      default: msg[15] = 32'h000001c0;
    endcase
    for (int i = 0; i < 16; i++) wexp[i] = msg[i];
    for (int i = 16; i < 80; i++) begin
      logic [31:0] x;
      x = wexp[i-3] ^ wexp[i-8] ^ wexp[i-14] ^ wexp[i-16];
      wexp[i] = {x[30:0], x[31]};
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, " in_ready"}, in_ready, 1'b1);
    chk({tag, " busy"}, busy, 1'b0);
    chk({tag, " digest_valid"}, digest_valid, 1'b0);
    chk({tag, " strobes"}, {feed, next}, 8'h00);
    chk({tag, " buses"}, {w, ia, ib, ic, id, ie}, 192'h0);
  endtask

  task automatic run_block(input string name, input bit gaps, input bit hold,
                           input bit with_init, input bit chk_bus,
                           input logic [159:0] bus_exp, input int abort_t);
    int idx = 0;
    int guard = 0;
    bit acc;
    while (idx < 16 && guard < 2000) begin
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = msg[idx];
      init     = with_init && (idx == 0) && in_valid;
      acc      = in_valid && in_ready;
      @(posedge clk);
      #1;
      init = 1'b0;
      if (acc) idx++;
      guard++;
    end
    chk({name, " words loaded"}, idx, 16);
    if (idx < 16) return;
    // FEED cycle
    if (hold) begin in_valid = 1'b1; in_data = 32'hdeadbeef; end
    else in_valid = 1'b0;
    chk({name, " feed@FEED"}, {feed, next}, 8'b0001_0000);
    chk({name, " in_ready@FEED"}, in_ready, 1'b0);
    if (chk_bus) chk({name, " bus@FEED"}, {ia, ib, ic, id, ie}, bus_exp);
    for (int t = 0; t < 80; t++) begin
      logic [3:0] ef, en;
      @(posedge clk);
      #1;
      ef = '0;
      en = '0;
      if (t % 20 == 19 && t < 79) ef[t/20+1] = 1'b1;
      else en[t/20] = 1'b1;
      chk($sformatf("%s feed t=%0d", name, t), feed, ef);
      chk($sformatf("%s next t=%0d", name, t), next, en);
      chk($sformatf("%s w t=%0d", name, t), w, wexp[t]);
      chk($sformatf("%s ready/dv t=%0d", name, t), {in_ready, digest_valid, busy}, 3'b001);
      if (t == abort_t) begin
        #2;
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        chk({name, " H after reset"}, {h0, h1, h2, h3, h4}, IV_H);
        check_idle_outputs({name, " in reset"});
        @(posedge clk);
        #1;
        reset = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk({name, " digest_valid@n+82"}, {digest_valid, in_ready, busy}, 3'b101);
    chk({name, " strobes@DONE"}, {feed, next}, 8'h00);
    @(posedge clk);
    #1;
    check_idle_outputs({name, " n+83"});
  endtask

  initial begin
    reset = 1'b1; init = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset H", {h0, h1, h2, h3, h4}, IV_H);
    check_idle_outputs("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;
    init = 1'b1;
    @(posedge clk);
    #1;
    init = 1'b0;
    chk("init H", {h0, h1, h2, h3, h4}, IV_H);

    set_block(0);
    run_block("abc", 1'b0, 1'b0, 1'b0, 1'b1, IV_H, -1);
    chk("abc digest", {h0, h1, h2, h3, h4}, ABC_H);

    set_block(0);
    run_block("abc gaps", 1'b1, 1'b1, 1'b1, 1'b1, IV_H, -1);
    chk("abc gaps digest", {h0, h1, h2, h3, h4}, ABC_H);

    set_block(1);
    run_block("empty", 1'b0, 1'b0, 1'b1, 1'b1, IV_H, -1);
    chk("empty digest", {h0, h1, h2, h3, h4}, EMP_H);

    set_block(2);
    run_block("two blk1", 1'b0, 1'b0, 1'b1, 1'b1, IV_H, -1);
    set_block(3);
    run_block("two blk2", 1'b0, 1'b0, 1'b0, 1'b0, '0, -1);
    chk("two-block digest", {h0, h1, h2, h3, h4}, TWO_H);

    set_block(0);
    run_block("abort", 1'b0, 1'b1, 1'b0, 1'b1, TWO_H, 40);
    @(posedge clk);
    #1;
    check_idle_outputs("after abort");
    init = 1'b1;
    @(posedge clk);
    #1;
    init = 1'b0;
    set_block(0);
    run_block("abc resend", 1'b0, 1'b0, 1'b0, 1'b1, IV_H, -1);
    chk("abc resend digest", {h0, h1, h2, h3, h4}, ABC_H);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
